// File: rtl/pc_gen_pkg.sv
// Shared control encodings: next-PC selector codes and PC reset/exception defaults.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        NPC_PLUS4  = 3'b000,
        NPC_BRANCH = 3'b001,
        NPC_JUMP   = 3'b010,
        NPC_JR     = 3'b011,
        NPC_EXC    = 3'b100,
        NPC_ERET   = 3'b101,
        NPC_JAL    = 3'b110,
        NPC_RET    = 3'b111
    } npc_op_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a pop when empty is ignored.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_count;
    logic             w_doPop;

    assign w_doPop = i_pop && (r_count != '0);

    // r_ptr marks the next free slot; DEPTH is a power of two so it wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_ptr <= r_ptr + PW'(1);
            if (r_count != CW'(DEPTH)) begin
                r_count <= r_count + CW'(1);
            end
        end else if (w_doPop) begin
            r_ptr   <= r_ptr - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && i_push) begin
            r_mem[r_ptr] <= i_data;
        end
    end

    assign o_top   = r_mem[r_ptr - PW'(1)];
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/pc_gen.sv
// Program counter and next-PC selection with exception return register.
// Optional return-address stack is built when NPC_RAS_EN is defined.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int          AW        = 32,
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
    parameter int          RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    NPCOp,
    input  logic          br_taken,
    input  logic [25:0]   IMM,
    input  logic [AW-1:0] RS,
    output logic [AW-1:0] PC,
    output logic [AW-1:0] NPC,
    output logic [AW-1:0] EPC,
    output logic          ras_empty
);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_epc;
    logic [AW-1:0] w_npc;
    logic [AW-1:0] w_pcPlus4;
    logic [AW-1:0] w_brOffset;
    logic [AW-1:0] w_jumpTarget;
    npc_op_e       w_op;

    assign w_op         = npc_op_e'(NPCOp);
    assign w_pcPlus4    = r_pc + AW'(4);
    assign w_brOffset   = {{(AW-18){IMM[15]}}, IMM[15:0], 2'b00};
    assign w_jumpTarget = {r_pc[AW-1:28], IMM, 2'b00};

`ifdef NPC_RAS_EN
    logic [AW-1:0] w_rasTop;
    logic          w_rasEmpty;
    logic          w_rasPush;
    logic          w_rasPop;

    assign w_rasPush = en && (w_op == NPC_JAL);
    assign w_rasPop  = en && (w_op == NPC_RET) && !w_rasEmpty;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (AW)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rasPush),
        .i_pop   (w_rasPop),
        .i_data  (w_pcPlus4),
        .o_top   (w_rasTop),
        .o_empty (w_rasEmpty)
    );

    assign ras_empty = w_rasEmpty;
`else
    assign ras_empty = 1'b1;
`endif

    always_comb begin
        w_npc = w_pcPlus4;
        case (w_op)
            NPC_PLUS4:  w_npc = w_pcPlus4;
            NPC_BRANCH: w_npc = br_taken ? (w_pcPlus4 + w_brOffset) : w_pcPlus4;
            NPC_JUMP:   w_npc = w_jumpTarget;
            NPC_JR:     w_npc = RS;
            NPC_EXC:    w_npc = EXC_VEC[AW-1:0];
            NPC_ERET:   w_npc = r_epc;
            NPC_JAL:    w_npc = w_jumpTarget;
`ifdef NPC_RAS_EN
            NPC_RET:    w_npc = w_rasEmpty ? RS : w_rasTop;
`else
            NPC_RET:    w_npc = RS;
`endif
            default:    w_npc = w_pcPlus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_PC[AW-1:0];
            r_epc <= '0;
        end else if (en) begin
            r_pc <= w_npc;
            if (w_op == NPC_EXC) begin
                r_epc <= r_pc;
            end
        end
    end

    assign PC  = r_pc;
    assign NPC = w_npc;
    assign EPC = r_epc;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; covers the RAS path when NPC_RAS_EN is defined.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  NPCOp;
    logic        br_taken;
    logic [25:0] IMM;
    logic [31:0] RS;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic [31:0] EPC;
    logic        ras_empty;

    int testCount = 0;
    int failCount = 0;

    pc_gen #(
        .AW        (32),
        .RESET_PC  (32'h0000_3000),
        .EXC_VEC   (32'h0000_4180),
        .RAS_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .NPCOp     (NPCOp),
        .br_taken  (br_taken),
        .IMM       (IMM),
        .RS        (RS),
        .PC        (PC),
        .NPC       (NPC),
        .EPC       (EPC),
        .ras_empty (ras_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic taken, input logic [25:0] imm,
                                 input logic [31:0] rs, input logic enable);
        NPCOp    = op;
        br_taken = taken;
        IMM      = imm;
        RS       = rs;
        en       = enable;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef NPC_RAS_EN
    logic [31:0] retTargets [5] = '{32'h3404, 32'h3304, 32'h3204, 32'h3104, 32'hDEAD0};
`endif

    initial begin
        rst = 1'b1;
        applyStimulus(NPC_EXC, 1'b0, 26'h0, 32'h0, 1'b1);
        tick();
        checkOutput("reset PC", PC, 32'h3000);
        checkOutput("reset EPC", EPC, 32'h0);
        checkOutput("reset ras_empty", {31'b0, ras_empty}, 32'h1);
        rst = 1'b0;

        applyStimulus(NPC_PLUS4, 1'b0, 26'h0, 32'h0, 1'b1);
        checkOutput("plus4 NPC", NPC, 32'h3004);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput("plus4 PC", PC, 32'h3000 + 32'(i * 4));
        end

        applyStimulus(NPC_BRANCH, 1'b1, 26'h000FFFE, 32'h0, 1'b1);
        checkOutput("branch taken NPC", NPC, 32'h300C);
        applyStimulus(NPC_BRANCH, 1'b0, 26'h000FFFE, 32'h0, 1'b1);
        checkOutput("branch not-taken NPC", NPC, 32'h3014);
        applyStimulus(NPC_BRANCH, 1'b1, 26'h0000010, 32'h0, 1'b1);
        checkOutput("branch fwd NPC", NPC, 32'h3054);

        applyStimulus(NPC_JR, 1'b0, 26'h0, 32'h3020, 1'b1);
        checkOutput("jr NPC", NPC, 32'h3020);
        tick();
        checkOutput("jr PC", PC, 32'h3020);

        applyStimulus(NPC_EXC, 1'b0, 26'h0, 32'h0, 1'b1);
        checkOutput("exc NPC", NPC, 32'h4180);
        tick();
        checkOutput("exc PC", PC, 32'h4180);
        checkOutput("exc EPC", EPC, 32'h3020);
        applyStimulus(NPC_ERET, 1'b0, 26'h0, 32'h0, 1'b1);
        checkOutput("eret NPC", NPC, 32'h3020);
        tick();
        checkOutput("eret PC", PC, 32'h3020);
        checkOutput("eret EPC kept", EPC, 32'h3020);

        applyStimulus(NPC_JUMP, 1'b0, 26'h100, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall PC", PC, 32'h3020);
        end
        applyStimulus(NPC_JUMP, 1'b0, 26'h100, 32'h0, 1'b1);
        checkOutput("jump NPC", NPC, 32'h400);
        tick();
        checkOutput("jump PC", PC, 32'h400);

        applyStimulus(NPC_EXC, 1'b0, 26'h0, 32'h0, 1'b0);
        tick();
        checkOutput("stall exc PC", PC, 32'h400);
        checkOutput("stall exc EPC", EPC, 32'h3020);

        applyStimulus(NPC_JR, 1'b0, 26'h0, 32'h1234_5678, 1'b1);
        tick();
        applyStimulus(NPC_JUMP, 1'b0, 26'h3FF_FFFF, 32'h0, 1'b1);
        checkOutput("jump upper NPC", NPC, 32'h1FFF_FFFC);
        applyStimulus(NPC_JR, 1'b0, 26'h0, 32'hFFFF_FFFC, 1'b1);
        tick();
        applyStimulus(NPC_PLUS4, 1'b0, 26'h0, 32'h0, 1'b1);
        checkOutput("plus4 wrap NPC", NPC, 32'h0);
        applyStimulus(NPC_BRANCH, 1'b1, 26'h0000001, 32'h0, 1'b1);
        checkOutput("branch wrap NPC", NPC, 32'h4);

        rst = 1'b1;
        applyStimulus(NPC_EXC, 1'b0, 26'h0, 32'h0, 1'b1);
        tick();
        rst = 1'b0;
        checkOutput("midreset PC", PC, 32'h3000);
        checkOutput("midreset EPC", EPC, 32'h0);

`ifdef NPC_RAS_EN
        for (int i = 0; i < 5; i++) begin
            applyStimulus(NPC_JAL, 1'b0, 26'((32'h3100 + 32'(i) * 32'h100) >> 2), 32'h0, 1'b1);
            checkOutput("jal NPC", NPC, 32'h3100 + 32'(i) * 32'h100);
            tick();
        end
        checkOutput("jal PC", PC, 32'h3500);
        checkOutput("ras full nonempty", {31'b0, ras_empty}, 32'h0);
        applyStimulus(NPC_RET, 1'b0, 26'h0, 32'hDEAD0, 1'b0);
        tick();
        checkOutput("stall ret PC", PC, 32'h3500);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(NPC_RET, 1'b0, 26'h0, 32'hDEAD0, 1'b1);
            checkOutput("ret NPC", NPC, retTargets[i]);
            if (i == 4) begin
                checkOutput("ret ras_empty", {31'b0, ras_empty}, 32'h1);
            end
            tick();
            checkOutput("ret PC", PC, retTargets[i]);
        end
        rst = 1'b1;
        applyStimulus(NPC_JAL, 1'b0, 26'hC40, 32'h0, 1'b1);
        tick();
        rst = 1'b0;
        checkOutput("reset drops push", {31'b0, ras_empty}, 32'h1);
`else
        applyStimulus(NPC_JAL, 1'b0, 26'hC40, 32'h0, 1'b1);
        checkOutput("jal NPC", NPC, 32'h3100);
        tick();
        checkOutput("jal PC", PC, 32'h3100);
        checkOutput("jal ras_empty", {31'b0, ras_empty}, 32'h1);
        applyStimulus(NPC_RET, 1'b0, 26'h0, 32'h3ABC, 1'b1);
        checkOutput("ret NPC", NPC, 32'h3ABC);
        tick();
        checkOutput("ret PC", PC, 32'h3ABC);
        checkOutput("ret ras_empty", {31'b0, ras_empty}, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
